// File: rtl/morse_encoder_if.sv
// Character handshake plus serial Morse output bundle between a character source
// and the encoder.
interface morse_encoder_if;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;
    logic       saida;
    logic       saida_valida;
    logic       ocupado;
    logic       erro;

    modport master (
        output char_in, char_valid,
        input  char_ready, saida, saida_valida, ocupado, erro
    );

    modport slave (
        input  char_in, char_valid,
        output char_ready, saida, saida_valida, ocupado, erro
    );
endinterface

// File: rtl/morse_encoder.sv
// ASCII to 2-bit-per-symbol Morse serialiser: dot=11, dash=00, NC=10, NP=01.
// It accepts a new character in the last clock of the previous one, so output is gapless.
module morse_encoder #(
    parameter int BIT_CYCLES = 1,
    parameter bit LOWER_EN   = 1'b1
) (
    input logic            clock,
    input logic            reset,
    morse_encoder_if.slave bus
);
    localparam int HW = $clog2(BIT_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(BIT_CYCLES - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state_reg;
    logic [9:0]    shift_reg;
    logic [3:0]    bits_left_reg;
    logic [HW-1:0] hold_reg;
    logic          saida_reg, valida_reg, ocupado_reg, erro_reg;

    logic [7:0] ch;
    logic [7:0] offs;
    logic       is_letter, is_space, supported;
    logic [2:0] sym_len;
    logic [3:0] sym_pat;
    logic [9:0] letter_code, load_code;
    logic [3:0] load_count;
    logic       last_tick, xfer, do_load;

    always_comb begin
        ch = bus.char_in;
        if (LOWER_EN && ch >= 8'h61 && ch <= 8'h7A)
            ch = ch & 8'hDF;
    end

    assign is_letter = (ch >= 8'h41) && (ch <= 8'h5A);
    assign is_space  = (ch == 8'h20);
    assign supported = is_letter | is_space;
    assign offs      = ch - 8'h41;

    // Pattern is left-aligned, first symbol in bit 3, 1 = dash.
    always_comb begin
        case (offs[4:0])
            5'd0:    {sym_len, sym_pat} = {3'd2, 4'b0100}; // A
            5'd1:    {sym_len, sym_pat} = {3'd4, 4'b1000}; // B
            5'd2:    {sym_len, sym_pat} = {3'd4, 4'b1010}; // C
            5'd3:    {sym_len, sym_pat} = {3'd3, 4'b1000}; // D
            5'd4:    {sym_len, sym_pat} = {3'd1, 4'b0000}; // E
            5'd5:    {sym_len, sym_pat} = {3'd4, 4'b0010}; // F
            5'd6:    {sym_len, sym_pat} = {3'd3, 4'b1100}; // G
            5'd7:    {sym_len, sym_pat} = {3'd4, 4'b0000}; // H
            5'd8:    {sym_len, sym_pat} = {3'd2, 4'b0000}; // I
            5'd9:    {sym_len, sym_pat} = {3'd4, 4'b0111}; // J
            5'd10:   {sym_len, sym_pat} = {3'd3, 4'b1010}; // K
            5'd11:   {sym_len, sym_pat} = {3'd4, 4'b0100}; // L
            5'd12:   {sym_len, sym_pat} = {3'd2, 4'b1100}; // M
            5'd13:   {sym_len, sym_pat} = {3'd2, 4'b1000}; // N
            5'd14:   {sym_len, sym_pat} = {3'd3, 4'b1110}; // O
            5'd15:   {sym_len, sym_pat} = {3'd4, 4'b0110}; // P
            5'd16:   {sym_len, sym_pat} = {3'd4, 4'b1101}; // Q
            5'd17:   {sym_len, sym_pat} = {3'd3, 4'b0100}; // R
            5'd18:   {sym_len, sym_pat} = {3'd3, 4'b0000}; // S
            5'd19:   {sym_len, sym_pat} = {3'd1, 4'b1000}; // T
            5'd20:   {sym_len, sym_pat} = {3'd3, 4'b0010}; // U
            5'd21:   {sym_len, sym_pat} = {3'd4, 4'b0001}; // V
            5'd22:   {sym_len, sym_pat} = {3'd3, 4'b0110}; // W
            5'd23:   {sym_len, sym_pat} = {3'd4, 4'b1001}; // X
            5'd24:   {sym_len, sym_pat} = {3'd4, 4'b1011}; // Y
            5'd25:   {sym_len, sym_pat} = {3'd4, 4'b1100}; // Z
            default: {sym_len, sym_pat} = {3'd0, 4'b0000};
        endcase
    end

    // Slot gi carries symbol gi, the NC marker right after the last symbol, else padding.
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_slot
            if (gi < 4) begin : g_sym
                assign letter_code[9-2*gi -: 2] =
                    (3'(gi) < sym_len)  ? (sym_pat[3-gi] ? 2'b00 : 2'b11) :
                    (3'(gi) == sym_len) ? 2'b10 : 2'b00;
            end else begin : g_tail
                assign letter_code[9-2*gi -: 2] = (sym_len == 3'd4) ? 2'b10 : 2'b00;
            end
        end
    endgenerate

    assign load_code  = is_space ? 10'b01_0000_0000 : letter_code;
    assign load_count = is_space ? 4'd2 : ({sym_len, 1'b0} + 4'd2);

    assign last_tick      = (state_reg == SEND) && (hold_reg == '0) && (bits_left_reg == 4'd0);
    assign bus.char_ready = ~reset & ((state_reg == IDLE) | last_tick);
    assign xfer           = bus.char_valid & bus.char_ready;
    assign do_load        = xfer & supported;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            shift_reg     <= '0;
            bits_left_reg <= '0;
            hold_reg      <= '0;
            saida_reg     <= 1'b0;
            valida_reg    <= 1'b0;
            ocupado_reg   <= 1'b0;
            erro_reg      <= 1'b0;
        end else begin
            erro_reg <= xfer & ~supported;
            if (do_load) begin
                state_reg     <= SEND;
                saida_reg     <= load_code[9];
                shift_reg     <= {load_code[8:0], 1'b0};
                bits_left_reg <= load_count - 4'd1;
                hold_reg      <= HOLD_LOAD;
                valida_reg    <= (BIT_CYCLES == 1);
                ocupado_reg   <= 1'b1;
            end else if (state_reg == SEND && hold_reg != '0) begin
                hold_reg   <= hold_reg - HW'(1);
                valida_reg <= (hold_reg == HW'(1));
            end else if (state_reg == SEND && bits_left_reg != 4'd0) begin
                saida_reg     <= shift_reg[9];
                shift_reg     <= {shift_reg[8:0], 1'b0};
                bits_left_reg <= bits_left_reg - 4'd1;
                hold_reg      <= HOLD_LOAD;
                valida_reg    <= (BIT_CYCLES == 1);
            end else begin
                state_reg   <= IDLE;
                saida_reg   <= 1'b0;
                valida_reg  <= 1'b0;
                ocupado_reg <= 1'b0;
            end
        end
    end

    assign bus.saida        = saida_reg;
    assign bus.saida_valida = valida_reg;
    assign bus.ocupado      = ocupado_reg;
    assign bus.erro         = erro_reg;
endmodule

// File: tb/tb_morse_encoder.sv
// Directed bench for morse_encoder: a vector table of character strings with their
// expected bit streams, plus cycle-exact sequences for latency, BIT_CYCLES=3 and reset abort.
module tb_morse_encoder;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] drv_char = 8'h00;
    logic       drv_valid = 1'b0;
    int         sel = 0;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    morse_encoder_if if_a ();
    morse_encoder_if if_b ();
    morse_encoder_if if_c ();

    assign if_a.char_in    = drv_char;
    assign if_b.char_in    = drv_char;
    assign if_c.char_in    = drv_char;
    assign if_a.char_valid = drv_valid && (sel == 0);
    assign if_b.char_valid = drv_valid && (sel == 1);
    assign if_c.char_valid = drv_valid && (sel == 2);

    morse_encoder #(.BIT_CYCLES(1), .LOWER_EN(1'b1)) u_a (.clock(clock), .reset(reset), .bus(if_a.slave));
    morse_encoder #(.BIT_CYCLES(1), .LOWER_EN(1'b0)) u_b (.clock(clock), .reset(reset), .bus(if_b.slave));
    morse_encoder #(.BIT_CYCLES(3), .LOWER_EN(1'b1)) u_c (.clock(clock), .reset(reset), .bus(if_c.slave));

    logic m_ready, m_saida, m_valida, m_ocupado, m_erro;
    always_comb begin
        m_ready = if_a.char_ready; m_saida = if_a.saida; m_valida = if_a.saida_valida;
        m_ocupado = if_a.ocupado; m_erro = if_a.erro;
        if (sel == 1) begin
            m_ready = if_b.char_ready; m_saida = if_b.saida; m_valida = if_b.saida_valida;
            m_ocupado = if_b.ocupado; m_erro = if_b.erro;
        end else if (sel == 2) begin
            m_ready = if_c.char_ready; m_saida = if_c.saida; m_valida = if_c.saida_valida;
            m_ocupado = if_c.ocupado; m_erro = if_c.erro;
        end
    end

    typedef struct {
        int    sel;
        int    bc;
        string chars;
        string bits;
        int    nerr;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end else
            $display("ok   %s = %0d", name, got);
    endtask

    task automatic chk_str(input string name, input string got, input string exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got \"%s\", expected \"%s\"", name, got, exp);
        end else
            $display("ok   %s = \"%s\"", name, got);
    endtask

    // Streams a string through instance s with valid held, recording each sampled bit.
    task automatic run_vec(input int s, input int bc, input string chars, input string exp_bits,
                           input int exp_err);
        string got_bits;
        int idx, n_xfer, n_err, quiet, cyc, first_v, last_v;
        bit xfer, ocu_seen;
        got_bits = ""; idx = 0; n_xfer = 0; n_err = 0; quiet = 0; cyc = 0;
        first_v = -1; last_v = -1; ocu_seen = 1'b0;
        @(posedge clock); #1;
        sel = s;
        drv_char = chars[0];
        drv_valid = 1'b1;
        while (!(idx == chars.len() && quiet >= 3) && cyc < 3000) begin
            @(negedge clock);
            if (m_valida) begin
                got_bits = {got_bits, m_saida ? "1" : "0"};
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
            end
            if (m_erro) n_err++;
            if (m_ocupado) ocu_seen = 1'b1;
            xfer = drv_valid && m_ready;
            if (idx == chars.len() && !m_ocupado && !m_erro) quiet++;
            else quiet = 0;
            @(posedge clock); #1;
            cyc++;
            if (xfer) begin
                idx++;
                n_xfer++;
                if (idx < chars.len()) drv_char = chars[idx];
                else drv_valid = 1'b0;
            end
        end
        drv_valid = 1'b0;
        chk($sformatf("timeout[%s]", chars), int'(cyc >= 3000), 0);
        chk_str($sformatf("stream[%s]", chars), got_bits, exp_bits);
        chk($sformatf("transfers[%s]", chars), n_xfer, chars.len());
        chk($sformatf("erro_cycles[%s]", chars), n_err, exp_err);
        chk($sformatf("ocupado_seen[%s]", chars), int'(ocu_seen), int'(exp_bits.len() > 0));
        if (exp_err == 0 && exp_bits.len() > 0)
            chk($sformatf("gapless_span[%s]", chars), last_v - first_v, (exp_bits.len() - 1) * bc);
    endtask

    initial begin
        string e_bits, t_bits;
        vecs[0]  = '{0, 1, "AI", "110010111110", 0};
        vecs[1]  = '{0, 1, "EAI MANINHO",
                     {"1110", "110010", "111110", "01", "000010", "110010", "001110",
                      "111110", "001110", "1111111110", "00000010"}, 0};
        vecs[2]  = '{0, 1, "n", "001110", 0};
        vecs[3]  = '{0, 1, "5", "", 1};
        vecs[4]  = '{1, 1, "n", "", 1};
        vecs[5]  = '{1, 1, "5", "", 1};
        vecs[6]  = '{0, 1, "SOS", "111111100000001011111110", 0};
        vecs[7]  = '{0, 1, "z", "0000111110", 0};
        vecs[8]  = '{0, 1, "A5E", "1100101110", 1};
        vecs[9]  = '{0, 1, "QJ", "00001100101100000010", 0};
        vecs[10] = '{1, 1, "N ", "00111001", 0};
        vecs[11] = '{2, 3, "IE", "1111101110", 0};

        // Reset state
        @(negedge clock);
        chk("rst_ready", int'(if_a.char_ready), 0);
        chk("rst_saida", int'(if_a.saida), 0);
        chk("rst_valida", int'(if_a.saida_valida), 0);
        chk("rst_ocupado", int'(if_a.ocupado), 0);
        chk("rst_erro", int'(if_a.erro), 0);
        reset = 1'b0;
        #1;
        chk("rst_release_ready", int'(if_a.char_ready), 1);

        // "E" cycle-exact at BIT_CYCLES=1
        e_bits = "1110";
        @(posedge clock); #1;
        sel = 0; drv_char = 8'h45; drv_valid = 1'b1;
        @(posedge clock); #1;
        drv_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock);
            if (c <= 4) begin
                chk($sformatf("E_saida_c%0d", c), int'(m_saida), int'(e_bits[c-1] == "1"));
                chk($sformatf("E_valida_c%0d", c), int'(m_valida), 1);
                chk($sformatf("E_ready_c%0d", c), int'(m_ready), int'(c == 4));
            end else begin
                chk("E_ocupado_c5", int'(m_ocupado), 0);
                chk("E_valida_c5", int'(m_valida), 0);
            end
        end

        // "T" at BIT_CYCLES=3: each bit held three clocks, valid on the third
        t_bits = "0010";
        @(posedge clock); #1;
        sel = 2; drv_char = 8'h54; drv_valid = 1'b1;
        @(posedge clock); #1;
        drv_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            chk($sformatf("T3_saida_c%0d", c), int'(m_saida), int'(t_bits[(c-1)/3] == "1"));
            chk($sformatf("T3_valida_c%0d", c), int'(m_valida), int'(c % 3 == 0));
        end
        @(negedge clock);
        chk("T3_ocupado_after", int'(m_ocupado), 0);

        // Table-driven vectors
        for (int i = 0; i < 12; i++)
            run_vec(vecs[i].sel, vecs[i].bc, vecs[i].chars, vecs[i].bits, vecs[i].nerr);

        // Reset during the third bit of "O" aborts asynchronously
        @(posedge clock); #1;
        sel = 0; drv_char = 8'h4F; drv_valid = 1'b1;
        @(posedge clock); #1;
        drv_valid = 1'b0;
        repeat (3) @(negedge clock);
        chk("O_busy_before_reset", int'(m_ocupado), 1);
        reset = 1'b1;
        #1;
        chk("abort_saida", int'(m_saida), 0);
        chk("abort_valida", int'(m_valida), 0);
        chk("abort_ocupado", int'(m_ocupado), 0);
        chk("abort_ready", int'(m_ready), 0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        run_vec(0, 1, "E", "1110", 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/morse_encoder.md
Name: morse_encoder

Overview:
- Upstream neighbour of the Morse decoder. Converts ASCII characters, received over a valid/ready handshake, into the serial 2-bit-per-symbol stream the decoder reads on its `entrada` input.
- Symbol encoding, first bit on the wire first:
  - dot = 1,1
  - dash = 0,0
  - end of character (NC) = 1,0
  - word space (NP) = 0,1
- Drives the decoder directly, or feeds test and loopback paths.

Parameters:
- BIT_CYCLES, 1: clocks each output bit is held; legal range 1..255.
- LOWER_EN, 1: when 1, `a`..`z` are encoded as their uppercase letter; when 0, they are unsupported.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- char_in  in  8  ASCII character.
- char_valid  in  1  char_in is valid this cycle.
- char_ready  out  1  encoder can accept a character this cycle.
- saida  out  1  serial Morse bit.
- saida_valida  out  1  high on the last clock of each bit period; downstream samples saida only when this is high.
- ocupado  out  1  high while a character is being emitted.
- erro  out  1  one-cycle pulse when an unsupported character is accepted.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; saida=0, saida_valida=0, ocupado=0, erro=0.
  - char_ready is 0 while reset is high and 1 in the first cycle after release.
  - Reset asserted mid-character aborts it immediately. No partial NC is emitted, and the next character starts clean.
- Handshake:
  - Transfer occurs on a rising edge where char_valid & char_ready.
  - char_ready = (state==IDLE) | (state==SEND & last clock of last bit).
  - char_ready has no dependence on char_valid.
  - char_in is sampled only on a transfer.
- Accepted character, supported set:
  - A..Z, plus a..z when LOWER_EN=1: standard international code, 1 to 4 symbols, followed by NC.
  - 0x20 (space): NP only, with no NC.
- Accepted character, unsupported (anything else):
  - Nothing is emitted; state stays or returns to IDLE.
  - erro=1 for exactly the cycle after the transfer.
- Load:
  - The transfer loads a 10-bit shift register, MSB first, and a bit count.
  - Bit count = 2×symbols+2 for letters (range 4..10), or 2 for space.
- Emission:
  - The first bit appears on saida in the cycle after the transfer (latency 1).
  - Each bit is held BIT_CYCLES clocks, and saida_valida is high on the last of them. For BIT_CYCLES=1, saida_valida is continuously high while in SEND.
  - ocupado=1 throughout SEND.
- States:
  - IDLE → SEND on transfer of a supported character.
  - SEND → SEND when the last bit ends and a new transfer occurs in that cycle. This gives gapless back-to-back output, with the first bit of the new character in the very next clock.
  - SEND → IDLE when the last bit ends with no transfer.
- Idle output:
  - In IDLE, saida=0 and saida_valida=0.
- Unsupported character during the last-bit window:
  - It is accepted and erro pulses.
  - The FSM then goes to IDLE after the current bit completes.
- Counters:
  - Hold counter: ceil(log2(BIT_CYCLES+1)) bits, reloaded on every bit boundary.
  - Bit counter: 4 bits.
  - No wrap-around beyond a load.
- Lookup:
  - Combinational ROM of 26 entries, each a 3-bit length plus a 4-symbol pattern.
  - Lowercase is folded by clearing bit 5 only when LOWER_EN=1 and char_in is in 0x61..0x7A.

Test Plan:
- "E" (0x45), BIT_CYCLES=1:
  - Transfer at cycle 0 → saida=1,1,1,0 with saida_valida=1 on cycles 1–4.
  - char_ready=1 on cycle 4; ocupado=0 from cycle 5.
- Back-to-back "AI" with char_valid held high:
  - Stream = 1,1,0,0,1,0,1,1,1,1,1,0 with no gap.
  - Exactly 2 transfers occur.
- Stream "EAI MANINHO" (space included) → bit stream identical to the decoder's directed vector sequence.
  - Includes NC then NP between I and M.
  - H = 8×1 then 1,0; O = 6×0 then 1,0.
  - Decoder in loopback outputs E,A,I,space,M,A,N,I,N,H,O.
- Unsupported characters:
  - '5' (0x35) and 'n' with LOWER_EN=0 → accepted, erro pulses 1 cycle each, saida_valida stays 0, ocupado stays 0.
  - 'n' with LOWER_EN=1 → 0,0,1,1,1,0.
- BIT_CYCLES=3, "T" (0x54):
  - saida=0 for 3 clocks, then 0 for 3, then 1 for 3, then 0 for 3.
  - saida_valida high on clocks 3, 6, 9 and 12 only.
- Reset during the third bit of "O":
  - Outputs go to 0 asynchronously.
  - After release, "E" emits 1,1,1,0 normally.
